// File: rtl/comm_response_rx_pkg.sv
// Shared definitions for the command-link receive path: baud constants,
// response codes, ASCII delimiters, FSM state types and the line classifier.
package comm_response_rx_pkg;

    // clk cycles per bit at 50 MHz
    localparam int BAUD_115200 = 434;
    localparam int BAUD_57600  = 868;
    localparam int BAUD_38400  = 1302;
    localparam int BAUD_19200  = 2604;
    localparam int BAUD_9600   = 5208;

    localparam logic [2:0] RESP_NONE     = 3'd0;
    localparam logic [2:0] RESP_OK       = 3'd1;
    localparam logic [2:0] RESP_ERROR    = 3'd2;
    localparam logic [2:0] RESP_OTHER    = 3'd3;
    localparam logic [2:0] RESP_OVERFLOW = 3'd4;
    localparam logic [2:0] RESP_TIMEOUT  = 3'd5;

    localparam logic [7:0] ASCII_CR = 8'h0D;
    localparam logic [7:0] ASCII_LF = 8'h0A;

    typedef enum logic [1:0] {
        UR_HUNT,
        UR_START,
        UR_DATA,
        UR_STOP
    } uart_rx_state_e;

    typedef enum logic [2:0] {
        LN_IDLE,
        LN_RECV,
        LN_DISCARD,
        LN_MATCH,
        LN_REPORT
    } line_state_e;

    // Classify a completed line from its length and first five bytes
    // (byte i lives in head[8*i +: 8]). Exact, case-sensitive match.
    function automatic logic [2:0] resp_classify(input logic [6:0] len, input logic [39:0] head);
        logic [2:0] code;
        if ((len == 7'd2) && (head[15:0] == 16'h4B4F)) begin
            code = RESP_OK;
        end else if ((len == 7'd5) && (head == 40'h52_4F_52_52_45)) begin
            code = RESP_ERROR;
        end else begin
            code = RESP_OTHER;
        end
        return code;
    endfunction

endpackage

// File: rtl/comm_response_rx_uart_rx_core.sv
// 8N1 UART receiver: 2-FF synchroniser, falling-edge start detection with
// mid-start glitch rejection, LSB-first data sampling at mid-bit and stop
// bit check. Emits registered single-cycle byte_valid / frame_err pulses.
module uart_rx_core
    import comm_response_rx_pkg::*;
#(
    parameter int BAUD = BAUD_115200
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx,
    output logic [7:0] data,
    output logic       byte_valid,
    output logic       frame_err
);

    localparam logic [15:0] HALF_M1 = 16'(BAUD / 2 - 1);
    localparam logic [15:0] FULL_M1 = 16'(BAUD - 1);

    logic [2:0]     sync_r;
    logic           rx_s;
    logic           fall_s;
    uart_rx_state_e state_r, state_nx;
    logic [15:0]    cnt_r, cnt_nx;
    logic [2:0]     bit_r, bit_nx;
    logic [7:0]     shift_r, shift_nx;
    logic [7:0]     data_r, data_nx;
    logic           byte_valid_r, byte_valid_nx;
    logic           frame_err_r, frame_err_nx;

    // sync_r[1] is the synchronised line, sync_r[2] its previous value for edge detection
    assign rx_s   = sync_r[1];
    assign fall_s = sync_r[2] & ~sync_r[1];

    // Synchroniser; resets to the idle-high line level so no false start follows reset
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync_r <= 3'b111;
        end else begin
            sync_r <= {sync_r[1:0], rx};
        end
    end

    // Bit-timing state register and output registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r      <= UR_HUNT;
            cnt_r        <= 16'd0;
            bit_r        <= 3'd0;
            shift_r      <= 8'd0;
            data_r       <= 8'd0;
            byte_valid_r <= 1'b0;
            frame_err_r  <= 1'b0;
        end else begin
            state_r      <= state_nx;
            cnt_r        <= cnt_nx;
            bit_r        <= bit_nx;
            shift_r      <= shift_nx;
            data_r       <= data_nx;
            byte_valid_r <= byte_valid_nx;
            frame_err_r  <= frame_err_nx;
        end
    end

    // Next-state, bit counter and sampling decisions
    always_comb begin
        state_nx      = state_r;
        cnt_nx        = cnt_r;
        bit_nx        = bit_r;
        shift_nx      = shift_r;
        data_nx       = data_r;
        byte_valid_nx = 1'b0;
        frame_err_nx  = 1'b0;
        case (state_r)
            UR_HUNT: begin
                if (fall_s) begin
                    state_nx = UR_START;
                    cnt_nx   = 16'd0;
                end else begin
                    cnt_nx   = 16'd0;
                end
            end
            UR_START: begin
                if (cnt_r == HALF_M1) begin
                    cnt_nx = 16'd0;
                    bit_nx = 3'd0;
                    if (rx_s) begin
                        state_nx = UR_HUNT;
                    end else begin
                        state_nx = UR_DATA;
                    end
                end else begin
                    cnt_nx = cnt_r + 16'd1;
                end
            end
            UR_DATA: begin
                if (cnt_r == FULL_M1) begin
                    cnt_nx   = 16'd0;
                    shift_nx = {rx_s, shift_r[7:1]};
                    if (bit_r == 3'd7) begin
                        state_nx = UR_STOP;
                    end else begin
                        bit_nx = bit_r + 3'd1;
                    end
                end else begin
                    cnt_nx = cnt_r + 16'd1;
                end
            end
            UR_STOP: begin
                if (cnt_r == FULL_M1) begin
                    cnt_nx   = 16'd0;
                    state_nx = UR_HUNT;
                    if (rx_s) begin
                        byte_valid_nx = 1'b1;
                        data_nx       = shift_r;
                    end else begin
                        frame_err_nx  = 1'b1;
                    end
                end else begin
                    cnt_nx = cnt_r + 16'd1;
                end
            end
            default: begin
                state_nx = UR_HUNT;
                cnt_nx   = 16'd0;
            end
        endcase
    end

    assign data       = data_r;
    assign byte_valid = byte_valid_r;
    assign frame_err  = frame_err_r;

endmodule

// File: rtl/comm_response_rx.sv
// Receive side of the command link: collects LF-terminated ASCII lines from
// the UART into a line buffer, classifies them (OK / ERROR / OTHER, or
// OVERFLOW / TIMEOUT) and holds the result until the controller acks.
module comm_response_rx
    import comm_response_rx_pkg::*;
#(
    parameter int BAUD     = BAUD_115200,
    parameter int LINE_MAX = 32,
    parameter int TIMEOUT  = 50000000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx,
    output logic       resp_valid,
    output logic [2:0] resp_code,
    output logic [5:0] resp_len,
    input  logic       resp_ack,
    input  logic [5:0] rd_addr,
    output logic [7:0] rd_data,
    output logic       frame_err,
    output logic       overrun
);

    localparam int          AW         = $clog2(LINE_MAX);
    localparam logic [6:0]  LINE_MAX_W = 7'(LINE_MAX);
    localparam logic [26:0] TMO_LOAD   = 27'(TIMEOUT);

    logic [7:0]  rx_data_s;
    logic        byte_valid_s;
    logic        frame_err_s;
    logic        is_cr_s;
    logic        is_lf_s;

    line_state_e state_r, state_nx;
    logic [6:0]  wr_ptr_r, wr_ptr_nx;
    logic [26:0] tmo_r, tmo_nx;
    logic        valid_r, valid_nx;
    logic [2:0]  code_r, code_nx;
    logic [5:0]  len_r, len_nx;
    logic        overrun_r, overrun_nx;
    logic        buf_we_s;
    logic [39:0] head_r;
    logic [7:0]  buf_r [LINE_MAX];
    logic [7:0]  rd_data_r;

    uart_rx_core #(.BAUD(BAUD)) u_uart_rx_core (
        .clk        (clk),
        .rst        (rst),
        .rx         (rx),
        .data       (rx_data_s),
        .byte_valid (byte_valid_s),
        .frame_err  (frame_err_s)
    );

    assign is_cr_s = (rx_data_s == ASCII_CR);
    assign is_lf_s = (rx_data_s == ASCII_LF);

    // Upper read-address bits are meaningless for shallow buffers
    generate
        if (AW < 6) begin : g_rd_addr_hi
            logic unused_rd_addr_s;
            assign unused_rd_addr_s = ^rd_addr[5:AW];
        end
    endgenerate

    // Line FSM state and response/pointer/timeout registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r   <= LN_IDLE;
            wr_ptr_r  <= 7'd0;
            tmo_r     <= 27'd0;
            valid_r   <= 1'b0;
            code_r    <= RESP_NONE;
            len_r     <= 6'd0;
            overrun_r <= 1'b0;
        end else begin
            state_r   <= state_nx;
            wr_ptr_r  <= wr_ptr_nx;
            tmo_r     <= tmo_nx;
            valid_r   <= valid_nx;
            code_r    <= code_nx;
            len_r     <= len_nx;
            overrun_r <= overrun_nx;
        end
    end

    // Line assembly, classification, timeout and handshake decisions
    always_comb begin
        state_nx   = state_r;
        wr_ptr_nx  = wr_ptr_r;
        tmo_nx     = tmo_r;
        valid_nx   = valid_r;
        code_nx    = code_r;
        len_nx     = len_r;
        overrun_nx = overrun_r;
        buf_we_s   = 1'b0;
        case (state_r)
            LN_IDLE: begin
                // blank lines (bare CR/LF) never start a line
                if (byte_valid_s && !is_cr_s && !is_lf_s) begin
                    buf_we_s  = 1'b1;
                    wr_ptr_nx = 7'd1;
                    tmo_nx    = TMO_LOAD;
                    state_nx  = LN_RECV;
                end else begin
                    state_nx  = LN_IDLE;
                end
            end
            LN_RECV: begin
                if (byte_valid_s) begin
                    tmo_nx = TMO_LOAD;
                    if (is_cr_s) begin
                        state_nx = LN_RECV;
                    end else if (is_lf_s) begin
                        state_nx = LN_MATCH;
                    end else if (wr_ptr_r < LINE_MAX_W) begin
                        buf_we_s  = 1'b1;
                        wr_ptr_nx = wr_ptr_r + 7'd1;
                    end else begin
                        state_nx = LN_DISCARD;
                    end
                end else if (tmo_r == 27'd0) begin
                    code_nx  = RESP_TIMEOUT;
                    len_nx   = wr_ptr_r[5:0];
                    valid_nx = 1'b1;
                    state_nx = LN_REPORT;
                end else begin
                    tmo_nx = tmo_r - 27'd1;
                end
            end
            LN_DISCARD: begin
                if (byte_valid_s && is_lf_s) begin
                    code_nx  = RESP_OVERFLOW;
                    len_nx   = LINE_MAX_W[5:0];
                    valid_nx = 1'b1;
                    state_nx = LN_REPORT;
                end else begin
                    state_nx = LN_DISCARD;
                end
            end
            LN_MATCH: begin
                code_nx  = resp_classify(wr_ptr_r, head_r);
                len_nx   = wr_ptr_r[5:0];
                valid_nx = 1'b1;
                state_nx = LN_REPORT;
            end
            LN_REPORT: begin
                // ack wins over a simultaneous byte, which is still flagged as overrun
                if (resp_ack) begin
                    valid_nx   = 1'b0;
                    code_nx    = RESP_NONE;
                    len_nx     = 6'd0;
                    wr_ptr_nx  = 7'd0;
                    overrun_nx = byte_valid_s;
                    state_nx   = LN_IDLE;
                end else if (byte_valid_s) begin
                    overrun_nx = 1'b1;
                end else begin
                    state_nx   = LN_REPORT;
                end
            end
            default: begin
                state_nx  = LN_IDLE;
                wr_ptr_nx = 7'd0;
                valid_nx  = 1'b0;
            end
        endcase
    end

    // Line buffer write port (inferred RAM, contents not reset)
    always_ff @(posedge clk) begin
        if (buf_we_s) begin
            buf_r[wr_ptr_r[AW-1:0]] <= rx_data_s;
        end
    end

    // Registered buffer read port
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_data_r <= 8'd0;
        end else begin
            rd_data_r <= buf_r[rd_addr[AW-1:0]];
        end
    end

    // Shadow copy of the first five bytes so the classifier needs no RAM ports
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            head_r <= 40'd0;
        end else if (buf_we_s && (wr_ptr_r < 7'd5)) begin
            head_r[{wr_ptr_r[2:0], 3'b000} +: 8] <= rx_data_s;
        end
    end

    assign resp_valid = valid_r;
    assign resp_code  = code_r;
    assign resp_len   = len_r;
    assign overrun    = overrun_r;
    assign rd_data    = rd_data_r;
    assign frame_err  = frame_err_s;

endmodule

// File: tb/tb_comm_response_rx.sv
// Self-checking bench for comm_response_rx: directed scenarios plus random
// lines, all compared against a byte-level line model kept in the bench.
// A short bit time keeps the run small; the bit timing scales with BAUD.
module tb_comm_response_rx;
    import comm_response_rx_pkg::*;

    localparam int BAUD     = 16;
    localparam int LINE_MAX = 32;
    localparam int TIMEOUT  = 1000;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       rx = 1'b1;
    logic       resp_ack = 1'b0;
    logic [5:0] rd_addr = 6'd0;
    logic       resp_valid;
    logic [2:0] resp_code;
    logic [5:0] resp_len;
    logic [7:0] rd_data;
    logic       frame_err;
    logic       overrun;

    always #5 clk = ~clk;

    comm_response_rx #(.BAUD(BAUD), .LINE_MAX(LINE_MAX), .TIMEOUT(TIMEOUT)) dut (
        .clk        (clk),
        .rst        (rst),
        .rx         (rx),
        .resp_valid (resp_valid),
        .resp_code  (resp_code),
        .resp_len   (resp_len),
        .resp_ack   (resp_ack),
        .rd_addr    (rd_addr),
        .rd_data    (rd_data),
        .frame_err  (frame_err),
        .overrun    (overrun)
    );

    int n_checks = 0;
    int n_fail   = 0;
    int fe_cycles = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // cycles during which frame_err is high
    always @(negedge clk) begin
        if (frame_err === 1'b1) fe_cycles++;
    end

    // ---------------- reference model (byte level) ----------------
    logic [7:0] m_line[$];
    logic [7:0] m_img [LINE_MAX];
    bit         m_in_line = 1'b0;
    bit         m_ovf     = 1'b0;
    bit         m_pending = 1'b0;
    bit         m_overrun = 1'b0;
    int         m_code    = 0;
    int         m_len     = 0;

    function automatic int model_classify();
        string ok_s  = "OK";
        string err_s = "ERROR";
        bit same;
        if (m_line.size() == 2) begin
            same = 1'b1;
            for (int i = 0; i < 2; i++) if (m_line[i] != ok_s[i]) same = 1'b0;
            if (same) return 1;
        end
        if (m_line.size() == 5) begin
            same = 1'b1;
            for (int i = 0; i < 5; i++) if (m_line[i] != err_s[i]) same = 1'b0;
            if (same) return 2;
        end
        return 3;
    endfunction

    task automatic model_byte(input logic [7:0] b);
        if (m_pending) begin
            m_overrun = 1'b1;
        end else if (b == 8'h0D) begin
            // carriage returns never reach the buffer
        end else if (b == 8'h0A) begin
            if (m_in_line) begin
                m_code    = m_ovf ? 4 : model_classify();
                m_len     = m_ovf ? LINE_MAX : m_line.size();
                m_pending = 1'b1;
                m_in_line = 1'b0;
            end
        end else begin
            if (!m_in_line) begin
                m_line.delete();
                m_ovf     = 1'b0;
                m_in_line = 1'b1;
            end
            if (!m_ovf) begin
                if (m_line.size() < LINE_MAX) begin
                    m_img[m_line.size()] = b;
                    m_line.push_back(b);
                end else begin
                    m_ovf = 1'b1;
                end
            end
        end
    endtask

    task automatic model_timeout();
        if (m_in_line && !m_ovf) begin
            m_code    = 5;
            m_len     = m_line.size();
            m_pending = 1'b1;
            m_in_line = 1'b0;
        end
    endtask

    task automatic model_ack();
        m_pending = 1'b0;
        m_overrun = 1'b0;
        m_code    = 0;
        m_len     = 0;
    endtask

    task automatic model_reset();
        model_ack();
        m_in_line = 1'b0;
        m_ovf     = 1'b0;
        m_line.delete();
    endtask

    // ---------------- stimulus helpers ----------------
    task automatic send_byte(input logic [7:0] b, input bit good_stop = 1'b1);
        @(negedge clk) rx = 1'b0;
        repeat (BAUD) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            repeat (BAUD) @(negedge clk);
        end
        rx = good_stop;
        repeat (BAUD) @(negedge clk);
        rx = 1'b1;
        if (!good_stop) repeat (BAUD) @(negedge clk);
        if (good_stop) model_byte(b);
    endtask

    task automatic send_str(input string s);
        for (int i = 0; i < s.len(); i++) send_byte(s[i]);
    endtask

    task automatic send_crlf();
        send_byte(8'h0D);
        send_byte(8'h0A);
    endtask

    task automatic check_pending(input string tag);
        chk({tag, ".valid"},   resp_valid, m_pending);
        chk({tag, ".code"},    resp_code,  m_code);
        chk({tag, ".len"},     resp_len,   m_len);
        chk({tag, ".overrun"}, overrun,    m_overrun);
        if (m_pending) begin
            for (int i = 0; i < m_len; i++) begin
                @(negedge clk) rd_addr = 6'(i);
                @(negedge clk);
                chk($sformatf("%s.buf%0d", tag, i), rd_data, m_img[i]);
            end
        end
    endtask

    task automatic do_ack(input string tag);
        @(negedge clk) resp_ack = 1'b1;
        @(negedge clk) resp_ack = 1'b0;
        model_ack();
        chk({tag, ".ack_valid"},   resp_valid, 0);
        chk({tag, ".ack_code"},    resp_code,  0);
        chk({tag, ".ack_len"},     resp_len,   0);
        chk({tag, ".ack_overrun"}, overrun,    0);
    endtask

    task automatic read_expect(input string tag, input logic [5:0] a, input logic [7:0] exp);
        @(negedge clk) rd_addr = a;
        @(negedge clk);
        chk(tag, rd_data, exp);
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, ".valid"},   resp_valid, 0);
        chk({tag, ".code"},    resp_code,  0);
        chk({tag, ".len"},     resp_len,   0);
        chk({tag, ".rd_data"}, rd_data,    0);
        chk({tag, ".fe"},      frame_err,  0);
        chk({tag, ".overrun"}, overrun,    0);
    endtask

    // ---------------- main sequence ----------------
    initial begin : main
        int fe0;
        int waited;
        logic [7:0] c;

        repeat (3) @(negedge clk);
        check_reset_outputs("reset");
        rst = 1'b1;
        repeat (5) @(negedge clk);

        // 1: OK
        send_str("OK");
        send_crlf();
        check_pending("t1");
        do_ack("t1");

        // 2: blank line then ERROR
        send_crlf();
        chk("t2.blank_valid", resp_valid, 0);
        send_str("ERROR");
        send_crlf();
        check_pending("t2");
        read_expect("t2.r0", 6'd0, 8'h45);
        read_expect("t2.r3", 6'd3, 8'h4F);
        read_expect("t2.r4", 6'd4, 8'h52);
        do_ack("t2");

        // 3: OTHER, then a line while pending -> overrun
        send_str("+CSQ: 12,0");
        send_crlf();
        check_pending("t3");
        read_expect("t3.r6", 6'd6, 8'h31);
        send_str("OK");
        send_crlf();
        chk("t3.overrun_set", overrun, 1);
        check_pending("t3b");
        do_ack("t3");

        // 4: overflow
        for (int i = 0; i < 40; i++) send_byte(8'h41);
        send_byte(8'h0A);
        check_pending("t4");
        chk("t4.code4", resp_code, 3'd4);
        read_expect("t4.r31", 6'd31, 8'h41);
        do_ack("t4");
        send_str("OK");
        send_crlf();
        check_pending("t4b");
        do_ack("t4b");

        // 5: timeout after partial line, then framing error
        send_str("OK");
        chk("t5.pre_timeout", resp_valid, 0);
        waited = 0;
        while (resp_valid !== 1'b1 && waited < TIMEOUT + 100) begin
            @(negedge clk);
            waited++;
        end
        chk("t5.timeout_seen", resp_valid, 1);
        model_timeout();
        check_pending("t5");
        do_ack("t5");
        fe0 = fe_cycles;
        send_byte(8'h55, 1'b0);
        chk("t5.fe_pulse", fe_cycles - fe0, 1);
        chk("t5.fe_no_resp", resp_valid, 0);
        send_str("OK");
        send_crlf();
        check_pending("t5b");
        do_ack("t5b");

        // 6: reset in the middle of "ERR"
        send_str("ER");
        @(negedge clk) rx = 1'b0;
        repeat (BAUD * 3) @(negedge clk);
        rst = 1'b0;
        model_reset();
        repeat (3) @(negedge clk);
        check_reset_outputs("t6.rst");
        rx = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        repeat (BAUD * 2) @(negedge clk);
        send_str("OK");
        send_crlf();
        check_pending("t6");
        chk("t6.code1", resp_code, 3'd1);
        do_ack("t6");

        // random lines
        for (int n = 0; n < 8; n++) begin
            int sel;
            int len;
            sel = $urandom_range(0, 5);
            if (sel == 0) begin
                send_str("OK");
            end else if (sel == 1) begin
                send_str("ERROR");
            end else if (sel == 2) begin
                send_str("ERRORS");
            end else begin
                len = $urandom_range(0, 38);
                for (int i = 0; i < len; i++) begin
                    if ($urandom_range(0, 9) == 0) c = 8'h0D;
                    else c = 8'($urandom_range(32, 126));
                    send_byte(c);
                end
            end
            if ($urandom_range(0, 1) == 1) send_crlf();
            else send_byte(8'h0A);
            check_pending($sformatf("rnd%0d", n));
            if (m_pending) begin
                if ($urandom_range(0, 2) == 0) begin
                    send_str("AT");
                    send_byte(8'h0A);
                    check_pending($sformatf("rnd%0d_ovr", n));
                end
                do_ack($sformatf("rnd%0d", n));
            end
            repeat ($urandom_range(0, 40)) @(negedge clk);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin : watchdog
        #3000000;
        $display("FAIL watchdog: simulation did not complete within time limit");
        $fatal(1);
    end

endmodule
